// File: rtl/add_sub_pkg.sv
// -----------------------------------------------------------------------------
// add_sub_pkg
// Shared definitions for the serial adder/subtractor:
//   WIDTH_DEFAULT : default operand/result width
//   SLICE_DEFAULT : default number of bits processed per cycle
//   state_t       : control FSM states (IDLE, BUSY, DONE)
// -----------------------------------------------------------------------------
package add_sub_pkg;

   localparam int WIDTH_DEFAULT = 32;
   localparam int SLICE_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : add_sub_pkg

// File: rtl/nibble_add_sub_slice.sv
// -----------------------------------------------------------------------------
// nibble_add_sub_slice
// Combinational SLICE-bit ripple adder/subtractor slice.
// Ports:
//   a, b      : SLICE-bit operand slices
//   cin       : carry into the slice LSB
//   sub       : 1 inverts b (the +1 of A-B comes in through cin at slice 0)
//   s         : SLICE-bit sum slice
//   cout      : carry out of the slice MSB
//   c_msb_in  : carry into the slice MSB (used for signed overflow)
// -----------------------------------------------------------------------------
module nibble_add_sub_slice
   import add_sub_pkg::*;
#(
   parameter int SLICE = SLICE_DEFAULT
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic [SLICE-1:0] s,
   output logic             cout,
   output logic             c_msb_in
);

   logic [SLICE-1:0] b_eff;
   logic [SLICE:0]   c;

   assign b_eff = b ^ {SLICE{sub}};
   assign c[0]  = cin;

   generate
      for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
         assign s[gi]   = a[gi] ^ b_eff[gi] ^ c[gi];
         assign c[gi+1] = (a[gi] & b_eff[gi]) | (c[gi] & (a[gi] ^ b_eff[gi]));
      end
   endgenerate

   assign cout     = c[SLICE];
   assign c_msb_in = c[SLICE-1];

endmodule : nibble_add_sub_slice

// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
// Multi-cycle adder/subtractor processing SLICE bits per cycle, LSB first,
// with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operation request handshake (a, b, sub)
//   a, b                : WIDTH-bit operands
//   sub                 : 0 -> A+B, 1 -> A-B (A + ~B + 1)
//   out_valid/out_ready : result handshake
//   s                   : WIDTH-bit sum/difference
//   cout                : carry out of MSB (for subtraction 1 = no borrow)
//   ovf                 : two's-complement signed overflow
// Latency: out_valid rises WIDTH/SLICE edges after the accept edge; the
// release edge returns to IDLE without accepting, so one operation takes
// at least WIDTH/SLICE + 2 cycles.
// -----------------------------------------------------------------------------
module serial_add_sub
   import add_sub_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int SLICE = SLICE_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int NSLICES = WIDTH / SLICE;
   localparam int CW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;

   generate
      if ((WIDTH % SLICE) != 0 || SLICE < 1) begin : g_bad_params
         $error("serial_add_sub: WIDTH must be a positive multiple of SLICE");
      end
   endgenerate

   state_t            state_reg;
   state_t            state_next;

   logic [WIDTH-1:0]  a_reg;
   logic [WIDTH-1:0]  b_reg;
   logic              sub_reg;
   logic              carry_reg;
   logic [CW-1:0]     cnt_reg;
   logic [WIDTH-1:0]  work_reg;

   logic [SLICE-1:0]  slice_s;
   logic              slice_cout;
   logic              slice_c_msb_in;
   logic              last_slice;
   logic [WIDTH+SLICE-1:0] work_cat;
   logic [WIDTH-1:0]  work_next;

   // Operands are shifted right each BUSY cycle, so the active slice is
   // always the low SLICE bits.
   nibble_add_sub_slice #(
      .SLICE (SLICE)
   ) u_slice (
      .a        (a_reg[SLICE-1:0]),
      .b        (b_reg[SLICE-1:0]),
      .cin      (carry_reg),
      .sub      (sub_reg),
      .s        (slice_s),
      .cout     (slice_cout),
      .c_msb_in (slice_c_msb_in)
   );

   assign last_slice = (cnt_reg == CW'(NSLICES - 1));

   // New slice enters at the top; after NSLICES cycles slice 0 sits at the LSB.
   assign work_cat  = {slice_s, work_reg};
   assign work_next = work_cat[WIDTH+SLICE-1:SLICE];

   // ---------------- FSM state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------- FSM next state / outputs ----------------
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (last_slice) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg     <= '0;
         b_reg     <= '0;
         sub_reg   <= 1'b0;
         carry_reg <= 1'b0;
         cnt_reg   <= '0;
         work_reg  <= '0;
         s         <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  sub_reg   <= sub;
                  carry_reg <= sub;   // the +1 of A + ~B + 1
                  cnt_reg   <= '0;
               end
            end
            BUSY: begin
               a_reg     <= a_reg >> SLICE;
               b_reg     <= b_reg >> SLICE;
               carry_reg <= slice_cout;
               cnt_reg   <= cnt_reg + 1'b1;
               work_reg  <= work_next;
               // Visible outputs only change when the full result is ready.
               if (last_slice) begin
                  s    <= work_next;
                  cout <= slice_cout;
                  ovf  <= slice_c_msb_in ^ slice_cout;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule : serial_add_sub

// File: tb/tb_serial_add_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub
// Directed self-checking bench for serial_add_sub (WIDTH=32, SLICE=4).
// -----------------------------------------------------------------------------
module tb_serial_add_sub;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] s;
   logic        cout;
   logic        ovf;

   int checks   = 0;
   int failures = 0;

   serial_add_sub #(
      .WIDTH (32),
      .SLICE (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for in_ready, then present one operation for one edge.
   task automatic start_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                           input logic tsub);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      a        = ta;
      b        = tb_v;
      sub      = tsub;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Expect out_valid exactly on the 8th edge after the accept edge.
   task automatic wait_done(input string tag);
      int early;
      early = 0;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) early++;
      end
      chk({tag, "_early_valid"}, early, 32'd0);
      @(posedge clk); #1;
      chk({tag, "_valid_at_8"}, {31'd0, out_valid}, 32'd1);
   endtask

   task automatic chk_result(input string tag, input logic [31:0] es, input logic ec,
                             input logic eo);
      chk({tag, "_s"},    s,             es);
      chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
      chk({tag, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
      $display("op %s: s=%h cout=%0b ovf=%0b", tag, s, cout, ovf);
   endtask

   task automatic release_result(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_rel_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_rel_ready"}, {31'd0, in_ready},  32'd1);
   endtask

   task automatic full_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic tsub, input logic [31:0] es, input logic ec,
                          input logic eo);
      start_op(tag, ta, tb_v, tsub);
      wait_done(tag);
      chk_result(tag, es, ec, eo);
      release_result(tag);
   endtask

   initial begin
      int seen;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      sub       = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_s",         s,                  32'd0);
      chk("rst_cout",      {31'd0, cout},      32'd0);
      chk("rst_ovf",       {31'd0, ovf},       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Functional vectors
      full_op("add_simple", 32'h00000002, 32'h00000002, 1'b0, 32'h00000004, 1'b0, 1'b0);
      full_op("add_wrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
      full_op("add_ovf_p",  32'h67584132, 32'h32415867, 1'b0, 32'h99999999, 1'b0, 1'b1);
      full_op("add_ovf_n",  32'h99999999, 32'h99999999, 1'b0, 32'h33333332, 1'b1, 1'b1);
      full_op("sub_borrow", 32'h00000003, 32'h00000008, 1'b1, 32'hFFFFFFFB, 1'b0, 1'b0);
      full_op("sub_plain",  32'h00000006, 32'h00000003, 1'b1, 32'h00000003, 1'b1, 1'b0);
      full_op("sub_ovf",    32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

      // Backpressure, operand change during BUSY, no accept on release edge
      start_op("bp", 32'h12345678, 32'h11111111, 1'b0);
      chk("bp_busy_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_busy_s_hold",   s,                 32'h7FFFFFFF);
      a        = 32'hDEADBEEF;
      b        = 32'h0F0F0F0F;
      sub      = 1'b1;
      in_valid = 1'b1;
      wait_done("bp");
      chk_result("bp", 32'h23456789, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_hold_ready", {31'd0, in_ready},  32'd0);
         chk("bp_hold_s",     {s[31:2], cout, ovf}, {30'h08D159E2, 1'b0, 1'b0});
      end
      release_result("bp");
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp_idle_after", {31'd0, in_ready}, 32'd1);

      // Reset in the middle of BUSY
      start_op("rst_mid", 32'h00000010, 32'h00000020, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_s",     s,                  32'd0);
      chk("rst_mid_cout",  {31'd0, cout},      32'd0);
      chk("rst_mid_ovf",   {31'd0, ovf},       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen++;
      end
      chk("rst_mid_no_valid", seen, 32'd0);
      full_op("after_rst", 32'h0000000A, 32'h00000005, 1'b1, 32'h00000005, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule : tb_serial_add_sub

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have parameter SLICE, default 4, giving the bits processed per cycle.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands and op are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a new operation.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 selects A+B, 1 selects A-B.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port s, output, WIDTH bits: the sum or difference.
REQ-013 The block SHALL have port cout, output, 1 bit: carry out of the MSB; for subtraction, 1 means no borrow.
REQ-014 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 out_valid SHALL be 1 only in DONE.
REQ-018 On in_valid&&in_ready, the block SHALL register a, b and sub, preset the carry to sub, clear the slice counter, and enter BUSY.
REQ-019 For subtraction the block SHALL compute A + ~B + 1, with the inversion of B applied per slice.
REQ-020 In BUSY, each cycle SHALL process slice k, LSB-first (bits k*SLICE+SLICE-1 .. k*SLICE), store that slice of s, and carry the slice carry-out into the next cycle.
REQ-021 After WIDTH/SLICE BUSY cycles (8 at default) the block SHALL enter DONE; out_valid SHALL rise on the 8th rising edge after the accept edge.
REQ-022 On entry to DONE, cout SHALL equal the final slice carry-out, and ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-023 In DONE, s, cout and ovf SHALL hold stable until out_valid&&out_ready.
REQ-024 On the out_valid&&out_ready edge the block SHALL return to IDLE; no new operation SHALL be accepted on that same edge, giving a minimum of 10 cycles per operation.
REQ-025 in_valid, a, b and sub SHALL be ignored outside IDLE; operand changes during BUSY SHALL NOT affect the result.
REQ-026 s, cout and ovf SHALL retain the last result while in IDLE and BUSY, until overwritten at the next DONE entry.
REQ-027 WIDTH SHALL be an integer multiple of SLICE; a violation SHALL be flagged by an elaboration-time assertion.

Reset
REQ-028 Asserting rst_n low SHALL immediately force state to IDLE, in_ready to 1 (once out of reset), out_valid to 0, s to 0, cout to 0, ovf to 0, the counter to 0 and the carry to 0.
REQ-029 Reset during BUSY or DONE SHALL abandon the operation, and no out_valid SHALL follow.
REQ-030 Operation SHALL resume on the first rising clk edge after rst_n deasserts.

Structure
REQ-031 Shared package add_sub_pkg SHALL hold the WIDTH and SLICE defaults and the state enum type (IDLE, BUSY, DONE).
REQ-032 The combinational slice adder SHALL be one sub-module, nibble_add_sub_slice, with inputs a[SLICE], b[SLICE], cin and sub, and outputs s[SLICE], cout and c_msb_in (the carry into the slice MSB).
REQ-033 The slice sub-module SHALL be instantiated exactly once.

Verification
REQ-034 Bench scenario, simple add: a=00000002, b=00000002, sub=0 -> s=00000004, cout=0, ovf=0; out_valid 8 cycles after accept.
REQ-035 Bench scenario, wrap-around: a=FFFFFFFF, b=00000001, sub=0 -> s=00000000, cout=1, ovf=0.
REQ-036 Bench scenario, signed overflow: a=67584132, b=32415867, sub=0 -> s=99999999, cout=0, ovf=1; and a=99999999, b=99999999, sub=0 -> s=33333332, cout=1, ovf=1.
REQ-037 Bench scenario, subtraction with borrow: a=00000003, b=00000008, sub=1 -> s=FFFFFFFB, cout=0, ovf=0; and a=00000006, b=00000003, sub=1 -> s=00000003, cout=1.
REQ-038 Bench scenario, backpressure: hold out_ready=0 for 5 cycles in DONE -> s, cout and ovf stable, in_ready=0; a changed during BUSY leaves the result unchanged.
REQ-039 Bench scenario, reset mid-operation: pulse rst_n low at BUSY cycle 4 -> outputs 0, in_ready=1, no out_valid; the next operation completes correctly.
